leaf_stream_fifo: RTL and testbench
===================================

LEAF_STREAM_FIFO -- requirements
Module: leaf_stream_fifo

Interface
REQ-001 Parameter WIDTH, default 8: data width in bits.
REQ-002 Parameter DEPTH, default 4: entry count; power of two, >= 2.
REQ-003 Port clk  input  1: single clock; all logic on rising edge.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port in_valid  input  1: upstream (parent hierarchy stage) presents in_data.
REQ-006 Port in_ready  output  1: FIFO accepts in_data this cycle.
REQ-007 Port in_data  input  WIDTH: write payload.
REQ-008 Port out_valid  output  1: out_data holds the oldest entry.
REQ-009 Port out_ready  input  1: downstream consumes this cycle.
REQ-010 Port out_data  output  WIDTH: head-of-queue payload.
REQ-011 Port count  output  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-012 Port overflow  output  1: sticky flag; a write was attempted while full.

Function
REQ-013 Write transfer SHALL occur when in_valid && in_ready; read transfer when out_valid && out_ready.
REQ-014 in_ready SHALL equal (count != DEPTH), registered-state derived, with no combinational path from out_ready.
REQ-015 out_valid SHALL equal (count != 0); out_data SHALL be driven from the entry at the read pointer, zero-latency (no extra register stage).
REQ-016 Latency: an entry written at edge N SHALL appear at out_data/out_valid after edge N, i.e. one cycle minimum; no fall-through on empty.
REQ-017 Write and read pointers SHALL be $clog2(DEPTH) bits and wrap modulo DEPTH from DEPTH-1 to 0.
REQ-018 count SHALL increment on write-only, decrement on read-only, hold on both or neither.
REQ-019 Simultaneous write and read when full SHALL be impossible for writes (in_ready=0); when empty, read SHALL be impossible (out_valid=0).
REQ-020 Simultaneous write and read with 0 < count < DEPTH SHALL both complete; count unchanged.
REQ-021 Full: in_valid=1 with in_ready=0 SHALL not alter storage, pointers, or count, and SHALL set overflow to 1.
REQ-022 overflow SHALL remain 1 until rst.
REQ-023 Data SHALL leave in exactly the order written; no entry dropped or duplicated.
REQ-024 out_data while out_valid=0 is don't-care; benches SHALL not check it.

Reset
REQ-025 On rst=1 at a clock edge: write pointer, read pointer, count = 0; overflow = 0; out_valid = 0; in_ready = 1 from the following cycle.
REQ-026 Reset mid-operation SHALL discard all stored entries; transfers presented in the reset cycle SHALL be ignored.
REQ-027 Storage array SHALL not require reset.

Structure
REQ-028 A shared package leaf_stream_pkg SHALL hold default WIDTH/DEPTH constants and a count-width helper function.
REQ-029 The design SHALL be a single module; no sub-module.
REQ-030 Storage SHALL be an inferable register array of DEPTH x WIDTH.

Verification
REQ-031 Reset then write 0x11,0x22,0x33,0x44 with out_ready=0 -> count=4, in_ready=0 after 4th write, overflow=0.
REQ-032 From full, hold in_valid=1 with 0x55 one cycle -> overflow=1, count=4; then drain -> reads 0x11,0x22,0x33,0x44, 0x55 never appears, overflow stays 1.
REQ-033 count=2, in_valid=out_ready=1 for 6 cycles with incrementing data -> count stays 2, output sequence in order, pointers wrap past 3 with no loss.
REQ-034 Empty, out_ready=1, single write 0xA5 at edge N -> out_valid=0 before edge N, out_valid=1 with 0xA5 after edge N, consumed at edge N+1, count back to 0.
REQ-035 count=3, assert rst one cycle with in_valid=1 -> count=0, out_valid=0, overflow=0 next cycle; the reset-cycle write is absent.
REQ-036 Random valid/ready stress 10k cycles against a scoreboard queue -> zero mismatches, count always equals scoreboard depth.

Source files
------------

// File: rtl/leaf_stream_pkg.sv
// Shared constants and helpers for the leaf stream FIFO.
//   DEFAULT_WIDTH : default payload width in bits
//   DEFAULT_DEPTH : default entry count (power of two, >= 2)
//   count_width() : bits needed to hold an occupancy of 0..depth
package leaf_stream_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 4;

    // Occupancy must reach DEPTH itself, hence one bit more than the pointer.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/leaf_stream_fifo.sv
// Single-clock valid/ready stream FIFO with an occupancy count and a sticky
// overflow flag.
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset
//   in_valid  : upstream presents in_data
//   in_ready  : FIFO can accept in_data this cycle (registered, not full)
//   in_data   : write payload
//   out_valid : out_data holds the oldest entry (registered, not empty)
//   out_ready : downstream consumes this cycle
//   out_data  : head-of-queue payload, read straight from storage
//   count     : occupancy 0..DEPTH
//   overflow  : sticky, set by any write attempt while full; cleared by rst
module leaf_stream_fifo
    import leaf_stream_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_next;
    logic             in_ready_next;
    logic             out_valid_next;
    logic             overflow_next;
    logic             wr_en;
    logic             rd_en;

    // Next-state: pointers, occupancy, and the flags derived from it.
    always_comb begin
        wr_en          = 1'b0;
        rd_en          = 1'b0;
        wr_ptr_next    = wr_ptr;
        rd_ptr_next    = rd_ptr;
        count_next     = count;
        overflow_next  = overflow;

        wr_en = in_valid && in_ready;
        rd_en = out_valid && out_ready;

        // Pointers are exactly log2(DEPTH) bits, so the increment wraps.
        if (wr_en) begin
            wr_ptr_next = wr_ptr + PTR_W'(1);
        end
        if (rd_en) begin
            rd_ptr_next = rd_ptr + PTR_W'(1);
        end

        unique case ({wr_en, rd_en})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase

        if (in_valid && !in_ready) begin
            overflow_next = 1'b1;
        end

        // Flags are registered from the next occupancy so neither handshake
        // output has a combinational path from the other side.
        in_ready_next  = (count_next != CNT_W'(DEPTH));
        out_valid_next = (count_next != CNT_W'(0));
    end

    // Control state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_next;
            rd_ptr    <= rd_ptr_next;
            count     <= count_next;
            overflow  <= overflow_next;
            in_ready  <= in_ready_next;
            out_valid <= out_valid_next;
        end
    end

    // Storage array; no reset so it maps onto plain registers or RAM.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Head entry is visible without an extra register stage.
    assign out_data = mem[rd_ptr];

endmodule

// File: tb/tb_leaf_stream_fifo.sv
// Directed and scoreboard-checked bench for leaf_stream_fifo (WIDTH=8, DEPTH=4).
module tb_leaf_stream_fifo;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [2:0]       count;
    logic             overflow;

    int vectors    = 0;
    int miscompares = 0;

    leaf_stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_seq [4];
    logic [7:0] q [$];
    logic       m_wr;
    logic       m_rd;

    initial begin
        exp_seq[0] = 8'h11; exp_seq[1] = 8'h22; exp_seq[2] = 8'h33; exp_seq[3] = 8'h44;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_count",     32'(count),     32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_overflow",  32'(overflow),  32'd0);

        // Fill to full with out_ready low
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = exp_seq[i];
            step();
        end
        in_valid = 1'b0;
        check("fill_count",    32'(count),     32'd4);
        check("fill_in_ready", 32'(in_ready),  32'd0);
        check("fill_overflow", 32'(overflow),  32'd0);
        check("fill_head",     32'(out_data),  32'h11);

        // Write attempt while full
        in_valid = 1'b1; in_data = 8'h55;
        step();
        in_valid = 1'b0;
        check("ovf_flag",  32'(overflow), 32'd1);
        check("ovf_count", 32'(count),    32'd4);

        // Drain: original four in order, 0x55 absent
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_data",  32'(out_data),  32'(exp_seq[i]));
            step();
        end
        out_ready = 1'b0;
        check("drain_empty_valid", 32'(out_valid), 32'd0);
        check("drain_count",       32'(count),     32'd0);
        check("drain_ovf_sticky",  32'(overflow),  32'd1);
        check("drain_in_ready",    32'(in_ready),  32'd1);

        // No fall-through: single write into empty FIFO with out_ready high
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'hA5;
        check("ft_pre_valid", 32'(out_valid), 32'd0);
        step();
        in_valid = 1'b0;
        check("ft_valid", 32'(out_valid), 32'd1);
        check("ft_data",  32'(out_data),  32'hA5);
        check("ft_count", 32'(count),     32'd1);
        step();
        out_ready = 1'b0;
        check("ft_consumed_valid", 32'(out_valid), 32'd0);
        check("ft_consumed_count", 32'(count),     32'd0);

        // Simultaneous read/write at count=2 across pointer wrap
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h60 + i);
            step();
        end
        check("rw_start_count", 32'(count), 32'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_data = 8'(8'h62 + i);
            check("rw_head", 32'(out_data), 32'(8'h60 + i));
            step();
            check("rw_count", 32'(count), 32'd2);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            check("rw_tail", 32'(out_data), 32'(8'h66 + i));
            step();
        end
        out_ready = 1'b0;
        check("rw_end_count", 32'(count), 32'd0);

        // Reset mid-operation with a write presented in the reset cycle
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = 8'(8'h70 + i);
            step();
        end
        check("mid_count", 32'(count), 32'd3);
        rst = 1'b1; in_valid = 1'b1; in_data = 8'h99;
        step();
        rst = 1'b0; in_valid = 1'b0;
        check("mrst_count",     32'(count),     32'd0);
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_overflow",  32'(overflow),  32'd0);
        check("mrst_in_ready",  32'(in_ready),  32'd1);
        in_valid = 1'b1; in_data = 8'hB0;
        step();
        in_valid = 1'b0;
        check("post_rst_count", 32'(count),    32'd1);
        check("post_rst_data",  32'(out_data), 32'hB0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("post_rst_empty", 32'(count), 32'd0);

        // Random valid/ready stress against a queue model
        q.delete();
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = 8'($urandom);
            m_wr = in_valid && (q.size() != DEPTH);
            m_rd = out_ready && (q.size() != 0);
            if (q.size() != 0) begin
                check("st_head", 32'(out_data), 32'(q[0]));
            end
            step();
            if (m_rd) begin
                void'(q.pop_front());
            end
            if (m_wr) begin
                q.push_back(in_data);
            end
            check("st_count",     32'(count),     32'(q.size()));
            check("st_out_valid", 32'(out_valid), 32'(q.size() != 0));
            check("st_in_ready",  32'(in_ready),  32'(q.size() != DEPTH));
        end
        in_valid = 1'b0; out_ready = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
